// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single processor-memory port between icache (loads) and dcache
// (loads/stores), routing returned data tags back to the issuing cache.
module mem_bus_arbiter #(
    parameter int unsigned XLEN              = 32,
    parameter int unsigned STARVE_LIMIT      = 8,
    parameter int unsigned I_MAX_OUTSTANDING = 4,
    parameter int unsigned D_MAX_OUTSTANDING = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      Icache2mem_command,
    input  logic [XLEN-1:0] Icache2mem_addr,
    input  logic [1:0]      Dcache2mem_command,
    input  logic [XLEN-1:0] Dcache2mem_addr,
    input  logic [63:0]     Dcache2mem_data,
    input  logic [3:0]      mem2arb_response,
    input  logic [63:0]     mem2arb_data,
    input  logic [3:0]      mem2arb_tag,
    output logic [1:0]      arb2mem_command,
    output logic [XLEN-1:0] arb2mem_addr,
    output logic [63:0]     arb2mem_data,
    output logic [3:0]      arb2Icache_response,
    output logic [63:0]     arb2Icache_data,
    output logic [3:0]      arb2Icache_tag,
    output logic [3:0]      arb2Dcache_response,
    output logic [63:0]     arb2Dcache_data,
    output logic [3:0]      arb2Dcache_tag,
    output logic [3:0]      i_outstanding,
    output logic [3:0]      d_outstanding,
    output logic            starve_boost,
    output logic            spurious_tag
);

    localparam int unsigned CW = 4;
    localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [15:0]   r_valid;
    logic [15:0]   r_owner;     // 1 = dcache owns the tag
    logic [CW-1:0] r_i_out;
    logic [CW-1:0] r_d_out;
    logic [SW-1:0] r_starve_cnt;
    logic          r_boost;
    logic          r_spurious;

    logic          w_elig_i;
    logic          w_elig_d;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_accept_i;
    logic          w_accept_d;
    logic          w_load_acc_d;
    logic          w_ret_hit;
    logic          w_ret_miss;
    logic          w_ret_owner;
    logic          w_i_dec;
    logic          w_d_dec;
    logic [SW-1:0] w_starve_next;
    logic [CW-1:0] w_i_out_next;
    logic [CW-1:0] w_d_out_next;

    // Eligibility and zero-latency grant; the starvation boost lets icache win.
    always_comb begin
        w_elig_i  = (Icache2mem_command == BUS_LOAD) && (r_i_out < CW'(I_MAX_OUTSTANDING));
        w_elig_d  = (Dcache2mem_command == BUS_STORE) ||
                    ((Dcache2mem_command == BUS_LOAD) && (r_d_out < CW'(D_MAX_OUTSTANDING)));
        w_grant_d = w_elig_d && !(r_boost && w_elig_i);
        w_grant_i = w_elig_i && !w_grant_d;
        w_accept_i   = w_grant_i && (mem2arb_response != 4'd0);
        w_accept_d   = w_grant_d && (mem2arb_response != 4'd0);
        w_load_acc_d = w_accept_d && (Dcache2mem_command == BUS_LOAD);
    end

    // Memory-side command mux and response routing.
    always_comb begin
        arb2mem_command     = BUS_NONE;
        arb2mem_addr        = '0;
        arb2mem_data        = '0;
        arb2Icache_response = 4'd0;
        arb2Dcache_response = 4'd0;
        if (w_grant_d) begin
            arb2mem_command     = Dcache2mem_command;
            arb2mem_addr        = Dcache2mem_addr;
            arb2mem_data        = Dcache2mem_data;
            arb2Dcache_response = mem2arb_response;
        end else if (w_grant_i) begin
            arb2mem_command     = BUS_LOAD;
            arb2mem_addr        = Icache2mem_addr;
            arb2Icache_response = mem2arb_response;
        end
    end

    // Return-tag lookup uses the pre-update table, so a same-cycle re-accept
    // of the same tag still routes the return to its old owner.
    always_comb begin
        w_ret_hit   = (mem2arb_tag != 4'd0) && r_valid[mem2arb_tag];
        w_ret_miss  = (mem2arb_tag != 4'd0) && !r_valid[mem2arb_tag];
        w_ret_owner = r_owner[mem2arb_tag];
        w_i_dec     = w_ret_hit && !w_ret_owner;
        w_d_dec     = w_ret_hit && w_ret_owner;
        arb2Icache_tag  = w_i_dec ? mem2arb_tag : 4'd0;
        arb2Dcache_tag  = w_d_dec ? mem2arb_tag : 4'd0;
        arb2Icache_data = mem2arb_data;
        arb2Dcache_data = mem2arb_data;
    end

    // Next outstanding counts; simultaneous inc and dec cancel.
    always_comb begin
        w_i_out_next = r_i_out;
        w_d_out_next = r_d_out;
        case ({w_accept_i, w_i_dec})
            2'b10:   w_i_out_next = r_i_out + CW'(1);
            2'b01:   w_i_out_next = r_i_out - CW'(1);
            default: w_i_out_next = r_i_out;
        endcase
        case ({w_load_acc_d, w_d_dec})
            2'b10:   w_d_out_next = r_d_out + CW'(1);
            2'b01:   w_d_out_next = r_d_out - CW'(1);
            default: w_d_out_next = r_d_out;
        endcase
    end

    // Starvation counter counts every denied icache load cycle, including
    // cycles blocked by its own outstanding limit.
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (w_accept_i) begin
            w_starve_next = '0;
        end else if ((Icache2mem_command == BUS_LOAD) && (r_starve_cnt < SW'(STARVE_LIMIT))) begin
            w_starve_next = r_starve_cnt + SW'(1);
        end
    end

    // Tag-owner table; a later accept overrides a same-tag clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_owner <= '0;
        end else begin
            if (w_ret_hit) begin
                r_valid[mem2arb_tag] <= 1'b0;
            end
            if (w_accept_i) begin
                r_valid[mem2arb_response] <= 1'b1;
                r_owner[mem2arb_response] <= 1'b0;
            end else if (w_load_acc_d) begin
                r_valid[mem2arb_response] <= 1'b1;
                r_owner[mem2arb_response] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_i_out      <= '0;
            r_d_out      <= '0;
            r_starve_cnt <= '0;
            r_boost      <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            r_i_out      <= w_i_out_next;
            r_d_out      <= w_d_out_next;
            r_starve_cnt <= w_starve_next;
            r_boost      <= (w_starve_next >= SW'(STARVE_LIMIT));
            if (w_ret_miss) begin
                r_spurious <= 1'b1;
            end
        end
    end

    assign i_outstanding = r_i_out;
    assign d_outstanding = r_d_out;
    assign starve_boost  = r_boost;
    assign spurious_tag  = r_spurious;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  icmd;
    logic [31:0] iaddr;
    logic [1:0]  dcmd;
    logic [31:0] daddr;
    logic [63:0] ddata;
    logic [3:0]  mresp;
    logic [63:0] mdata;
    logic [3:0]  mtag;

    logic [1:0]  arb2mem_command;
    logic [31:0] arb2mem_addr;
    logic [63:0] arb2mem_data;
    logic [3:0]  ires;
    logic [63:0] idat;
    logic [3:0]  itag;
    logic [3:0]  dres;
    logic [63:0] ddat;
    logic [3:0]  dtag;
    logic [3:0]  i_out;
    logic [3:0]  d_out;
    logic        boost;
    logic        spur;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter dut (
        .clock               (clock),
        .reset               (reset),
        .Icache2mem_command  (icmd),
        .Icache2mem_addr     (iaddr),
        .Dcache2mem_command  (dcmd),
        .Dcache2mem_addr     (daddr),
        .Dcache2mem_data     (ddata),
        .mem2arb_response    (mresp),
        .mem2arb_data        (mdata),
        .mem2arb_tag         (mtag),
        .arb2mem_command     (arb2mem_command),
        .arb2mem_addr        (arb2mem_addr),
        .arb2mem_data        (arb2mem_data),
        .arb2Icache_response (ires),
        .arb2Icache_data     (idat),
        .arb2Icache_tag      (itag),
        .arb2Dcache_response (dres),
        .arb2Dcache_data     (ddat),
        .arb2Dcache_tag      (dtag),
        .i_outstanding       (i_out),
        .d_outstanding       (d_out),
        .starve_boost        (boost),
        .spurious_tag        (spur)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        icmd = 2'd0; iaddr = '0; dcmd = 2'd0; daddr = '0; ddata = '0;
        mresp = 4'd0; mdata = '0; mtag = 4'd0;
        #3;
        chk("rst_i_out", 64'(i_out), 64'd0);
        chk("rst_d_out", 64'(d_out), 64'd0);
        chk("rst_boost", 64'(boost), 64'd0);
        chk("rst_spur", 64'(spur), 64'd0);
        chk("rst_cmd", 64'(arb2mem_command), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single icache load, tag 3 returned later.
        icmd = 2'd1; iaddr = 32'h1000; ddata = 64'hFFFF; mresp = 4'd3;
        @(negedge clock);
        chk("t1_cmd", 64'(arb2mem_command), 64'd1);
        chk("t1_addr", 64'(arb2mem_addr), 64'h1000);
        chk("t1_data0", arb2mem_data, 64'd0);
        chk("t1_ires", 64'(ires), 64'd3);
        chk("t1_dres", 64'(dres), 64'd0);
        tick();
        icmd = 2'd0; mresp = 4'd0;
        chk("t1_iout1", 64'(i_out), 64'd1);
        repeat (4) tick();
        mtag = 4'd3; mdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clock);
        chk("t1_itag", 64'(itag), 64'd3);
        chk("t1_dtag", 64'(dtag), 64'd0);
        chk("t1_idat", idat, 64'h0123_4567_89AB_CDEF);
        chk("t1_ddat", ddat, 64'h0123_4567_89AB_CDEF);
        tick();
        mtag = 4'd0;
        chk("t1_iout0", 64'(i_out), 64'd0);

        // Starvation: dcache stores every cycle, icache load held.
        icmd = 2'd1; iaddr = 32'h2000;
        dcmd = 2'd2; daddr = 32'h3000; ddata = 64'hDEAD; mresp = 4'd5;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            chk("t2_dcmd", 64'(arb2mem_command), 64'd2);
            chk("t2_dres", 64'(dres), 64'd5);
            chk("t2_ires", 64'(ires), 64'd0);
            chk("t2_noboost", 64'(boost), 64'd0);
            tick();
        end
        @(negedge clock);
        chk("t2_boost", 64'(boost), 64'd1);
        chk("t2_icmd", 64'(arb2mem_command), 64'd1);
        chk("t2_iaddr", 64'(arb2mem_addr), 64'h2000);
        chk("t2_idata0", arb2mem_data, 64'd0);
        chk("t2_ires5", 64'(ires), 64'd5);
        chk("t2_dres0", 64'(dres), 64'd0);
        tick();
        chk("t2_boost_drop", 64'(boost), 64'd0);
        chk("t2_iout", 64'(i_out), 64'd1);
        @(negedge clock);
        chk("t2_dback", 64'(arb2mem_command), 64'd2);
        tick();
        icmd = 2'd0; dcmd = 2'd0; mresp = 4'd0; mtag = 4'd5;
        @(negedge clock);
        chk("t2_itag5", 64'(itag), 64'd5);
        tick();
        mtag = 4'd0;
        chk("t2_iout0", 64'(i_out), 64'd0);

        // Dcache load limit.
        dcmd = 2'd1;
        for (int t = 1; t <= 4; t++) begin
            daddr = 32'h4000 + 32'(t * 8); mresp = 4'(t);
            @(negedge clock);
            chk("t3_dres", 64'(dres), 64'(t));
            tick();
        end
        chk("t3_dout4", 64'(d_out), 64'd4);
        daddr = 32'h4100; mresp = 4'd6;
        @(negedge clock);
        chk("t3_blk_cmd", 64'(arb2mem_command), 64'd0);
        chk("t3_blk_dres", 64'(dres), 64'd0);
        tick();
        mtag = 4'd2;
        @(negedge clock);
        chk("t3_dtag2", 64'(dtag), 64'd2);
        chk("t3_itag0", 64'(itag), 64'd0);
        chk("t3_still_blk", 64'(arb2mem_command), 64'd0);
        tick();
        mtag = 4'd0;
        chk("t3_dout3", 64'(d_out), 64'd3);
        @(negedge clock);
        chk("t3_fwd_cmd", 64'(arb2mem_command), 64'd1);
        chk("t3_fwd_addr", 64'(arb2mem_addr), 64'h4100);
        chk("t3_fwd_dres", 64'(dres), 64'd6);
        tick();
        chk("t3_dout4b", 64'(d_out), 64'd4);
        dcmd = 2'd0; mresp = 4'd0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: mtag = 4'd1;
                1: mtag = 4'd3;
                2: mtag = 4'd4;
                default: mtag = 4'd6;
            endcase
            @(negedge clock);
            chk("t3_drain_dtag", 64'(dtag), 64'(mtag));
            tick();
        end
        mtag = 4'd0;
        chk("t3_dout0", 64'(d_out), 64'd0);

        // Same-cycle return and re-accept of tag 7.
        icmd = 2'd1; iaddr = 32'h1100; mresp = 4'd7;
        @(negedge clock);
        chk("t4_ires7", 64'(ires), 64'd7);
        tick();
        icmd = 2'd0; mresp = 4'd0;
        chk("t4_iout1", 64'(i_out), 64'd1);
        tick();
        mtag = 4'd7; dcmd = 2'd1; daddr = 32'h5000; mresp = 4'd7;
        @(negedge clock);
        chk("t4_itag7", 64'(itag), 64'd7);
        chk("t4_dtag0", 64'(dtag), 64'd0);
        chk("t4_dres7", 64'(dres), 64'd7);
        tick();
        dcmd = 2'd0; mresp = 4'd0;
        chk("t4_iout0", 64'(i_out), 64'd0);
        chk("t4_dout1", 64'(d_out), 64'd1);
        @(negedge clock);
        chk("t4_owner_d", 64'(dtag), 64'd7);
        chk("t4_owner_i", 64'(itag), 64'd0);
        tick();
        mtag = 4'd0;
        chk("t4_dout0", 64'(d_out), 64'd0);

        // Spurious tag.
        mtag = 4'd9;
        @(negedge clock);
        chk("t5_itag0", 64'(itag), 64'd0);
        chk("t5_dtag0", 64'(dtag), 64'd0);
        chk("t5_spur_pre", 64'(spur), 64'd0);
        tick();
        mtag = 4'd0;
        chk("t5_spur", 64'(spur), 64'd1);
        tick();
        chk("t5_spur_sticky", 64'(spur), 64'd1);

        // Mid-flight reset with two icache loads outstanding.
        icmd = 2'd1; mresp = 4'd1;
        tick();
        mresp = 4'd2;
        tick();
        icmd = 2'd0; mresp = 4'd0;
        chk("t6_iout2", 64'(i_out), 64'd2);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_iout", 64'(i_out), 64'd0);
        chk("t6_rst_boost", 64'(boost), 64'd0);
        chk("t6_rst_spur", 64'(spur), 64'd0);
        reset = 1'b1;
        mtag = 4'd1;
        @(negedge clock);
        chk("t6_drop_itag", 64'(itag), 64'd0);
        chk("t6_drop_dtag", 64'(dtag), 64'd0);
        tick();
        mtag = 4'd0;
        chk("t6_spur", 64'(spur), 64'd1);
        chk("t6_iout_stay", 64'(i_out), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single processor-memory port between the instruction cache (loads only) and the data cache (loads and stores).
- Each cycle it selects one requester's command and forwards it to memory, then returns the memory's same-cycle response tag only to that requester.
- A 15-entry tag-owner table routes each returned data tag to the cache that issued it.
- A starvation counter ensures the icache makes forward progress against a busy dcache.

Parameters:
- XLEN, 32, address width.
- STARVE_LIMIT, 8, consecutive denied icache request cycles before icache receives priority.
- I_MAX_OUTSTANDING, 4, maximum in-flight icache loads (1..15).
- D_MAX_OUTSTANDING, 4, maximum in-flight dcache loads (1..15); stores are not counted.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- Icache2mem_command  in  2  BUS_NONE=0 / BUS_LOAD=1; BUS_STORE from icache is treated as BUS_NONE.
- Icache2mem_addr  in  XLEN  icache line address.
- Dcache2mem_command  in  2  BUS_NONE / BUS_LOAD / BUS_STORE=2.
- Dcache2mem_addr  in  XLEN  dcache address.
- Dcache2mem_data  in  64  store data.
- mem2arb_response  in  4  memory accept tag; 0 = rejected.
- mem2arb_data  in  64  returned load data.
- mem2arb_tag  in  4  tag of returned data; 0 = none.
- arb2mem_command  out  2  forwarded command.
- arb2mem_addr  out  XLEN  forwarded address.
- arb2mem_data  out  64  forwarded store data.
- arb2Icache_response  out  4  response to icache.
- arb2Icache_data  out  64  equals mem2arb_data.
- arb2Icache_tag  out  4  mem2arb_tag if owned by icache, else 0.
- arb2Dcache_response  out  4  response to dcache.
- arb2Dcache_data  out  64  equals mem2arb_data.
- arb2Dcache_tag  out  4  mem2arb_tag if owned by dcache, else 0.
- i_outstanding  out  4  in-flight icache loads.
- d_outstanding  out  4  in-flight dcache loads.
- starve_boost  out  1  icache currently holds priority.
- spurious_tag  out  1  sticky: a nonzero return tag arrived with no table entry.

Behaviour:
- Requests are level-held. A requester keeps its command until it sees a nonzero response on its own response port. Each transfer is single-cycle: either accepted or rejected.
- Eligibility:
  - elig_i = Icache cmd==LOAD && i_outstanding < I_MAX_OUTSTANDING.
  - elig_d = (Dcache cmd==STORE) || (Dcache cmd==LOAD && d_outstanding < D_MAX_OUTSTANDING).
- Grant is combinational with zero latency:
  - grant_d = elig_d && !(starve_boost && elig_i).
  - grant_i = elig_i && !grant_d.
- Memory-side outputs: the granted requester's command, addr and data. With no grant, drive BUS_NONE, addr 0, data 0. Icache grants always drive arb2mem_data = 0.
- Response routing: the granted side receives mem2arb_response; the other side receives 0.
- accept_x = grant_x && mem2arb_response != 0.
- Tag table (15 entries, tags 1..15; each entry holds valid + owner bit):
  - Accepted LOAD with response t: valid[t]<=1, owner[t]<=requester, and that requester's outstanding count increments.
  - Accepted STORE: no table entry, no count change.
  - Return of tag t != 0 with valid[t]: forward t on the owner's tag port only (other tag port 0), then clear valid[t] and decrement the owner's count.
  - Return with !valid[t]: both tag ports 0, and spurious_tag <= 1.
  - Same tag returned and re-accepted in the same cycle: the return is routed using the old owner; the table entry ends valid with the new owner.
  - Same requester incrementing and decrementing in one cycle: its count is unchanged.
- Starvation counter (width clog2(STARVE_LIMIT)+1):
  - Increments each cycle icache command==LOAD && !accept_i, saturating at STARVE_LIMIT.
  - Clears on accept_i.
  - starve_boost = (counter >= STARVE_LIMIT), which is registered state.
  - Cycles where the icache is blocked by its own outstanding limit also count.
- Reset (asynchronous, reset==0): table valids 0, both counts 0, starvation counter 0, starve_boost 0, spurious_tag 0.
  - Combinational outputs follow from the cleared state: arb2mem_command reflects current inputs, and response/tag ports route per the cleared table.
  - Data returning after a mid-operation reset for pre-reset tags is dropped (tag ports 0) and sets spurious_tag once reset is released.
- Memory tag 0 is never entered into the table.

Test Plan:
- Icache LOAD 0x1000 alone, mem response 3, tag 3 returned 5 cycles later.
  - Issue cycle: arb2mem_command=LOAD, addr 0x1000, arb2Icache_response=3, arb2Dcache_response=0.
  - Return cycle: arb2Icache_tag=3, arb2Dcache_tag=0, i_outstanding 1 then 0.
- Both request every cycle; dcache stores always accepted (response 5); icache LOAD held.
  - Dcache is granted for cycles 0..7 and starve_boost rises at cycle 8.
  - Icache is granted at cycle 8; boost drops the next cycle after accept_i.
- Dcache issues 4 LOADs (tags 1..4) with no returns, then a 5th LOAD while icache idles → arb2mem_command=NONE and arb2Dcache_response=0.
  - Return tag 2 → d_outstanding drops to 3 and the next dcache LOAD is forwarded.
- Icache load gets tag 7; in a later single cycle tag 7 returns while a dcache load is accepted with response 7 → arb2Icache_tag=7 that cycle; afterwards owner[7]=dcache and i_outstanding=0, d_outstanding=1.
- mem2arb_tag=9 with no entry → both tag ports 0 and spurious_tag=1 from the next cycle until reset.
- Reset pulsed low mid-flight with 2 icache loads outstanding → counts, boost and table clear immediately. A later return of one of those tags is dropped and sets spurious_tag.
